// File: rtl/usr_pkg.sv
// Shared types for the universal burst shift register: operation modes and
// the two-state burst controller.
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        SHL  = 3'b001,
        SHR  = 3'b010,
        LOAD = 3'b011,
        ROL  = 3'b100,
        ROR  = 3'b101,
        ASR  = 3'b110,
        RSVD = 3'b111
    } usr_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_t;

    // Modes that take part in a multi-cycle burst; the rest finish in one edge.
    function automatic logic is_burst_mode(input usr_mode_t m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One single-bit step of the selected shift/rotate operation, plus the bit
// that falls off the end. Purely combinational.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  usr_mode_t        mode,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next,
    output logic             exited
);

    always_comb begin
        q_next = q;
        exited = 1'b0;
        case (mode)
            SHL: begin
                q_next = {q[WIDTH-2:0], sin};
                exited = q[WIDTH-1];
            end
            SHR: begin
                q_next = {sin, q[WIDTH-1:1]};
                exited = q[0];
            end
            ROL: begin
                q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                exited = q[WIDTH-1];
            end
            ROR: begin
                q_next = {q[0], q[WIDTH-1:1]};
                exited = q[0];
            end
            ASR: begin
                q_next = {q[WIDTH-1], q[WIDTH-1:1]};
                exited = q[0];
            end
            default: begin
                q_next = q;
                exited = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/usr_burst.sv
// Universal shift register that runs a programmable number of single-bit
// steps per start command, reporting busy while running and a done pulse.
module usr_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    usr_state_t       state;
    usr_mode_t        cur_mode;
    usr_mode_t        cmd_mode;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    assign cmd_mode = usr_mode_t'(mode);

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q),
        .mode   (cur_mode),
        .sin    (sin),
        .q_next (step_q),
        .exited (step_out)
    );

    // In IDLE only start is looked at; once in SHIFT the latched mode and
    // count drive everything, so command inputs may wander freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_mode  <= HOLD;
            remaining <= '0;
            q         <= '0;
            sout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cmd_mode == LOAD) begin
                            q    <= pin;
                            done <= 1'b1;
                        end else if (is_burst_mode(cmd_mode) && (count != '0)) begin
                            cur_mode  <= cmd_mode;
                            remaining <= count;
                            busy      <= 1'b1;
                            state     <= SHIFT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    q         <= step_q;
                    sout      <= step_out;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cur_mode <= HOLD;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_burst.sv
// Directed bench for usr_burst (WIDTH=8): a reference model pushes expected
// per-edge snapshots into a scoreboard queue that is popped as edges occur.
module tb_usr_burst;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic [7:0] q;
        logic       sout;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    exp_t       sb[$];
    logic [7:0] mq;
    logic       msout;
    int         total;
    int         bad;

    usr_burst #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .count (count),
        .sin   (sin),
        .pin   (pin),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want test end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExp(input logic [7:0] eq, input logic es, input logic eb,
                           input logic ed, input string tag);
        exp_t e;
        e.q    = eq;
        e.sout = es;
        e.busy = eb;
        e.done = ed;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic modelStep(input logic [2:0] m, input logic s);
        case (m)
            3'b001: begin msout = mq[7]; mq = (mq << 1) | {7'b0, s}; end
            3'b010: begin msout = mq[0]; mq = (mq >> 1) | {s, 7'b0}; end
            3'b100: begin msout = mq[7]; mq = (mq << 1) | (mq >> 7); end
            3'b101: begin msout = mq[0]; mq = (mq >> 1) | (mq << 7); end
            3'b110: begin msout = mq[0]; mq = 8'($signed(mq) >>> 1); end
            default: ;
        endcase
    endtask

    // Expected snapshot after each edge from E0 to the done edge.
    task automatic pushCmd(input logic [2:0] m, input logic [3:0] cnt,
                           input logic [7:0] p, input logic s, input string tag);
        if (m == 3'b011) begin
            mq = p;
            pushExp(mq, msout, 1'b0, 1'b1, tag);
        end else if (m == 3'b000 || m == 3'b111 || cnt == 4'd0) begin
            pushExp(mq, msout, 1'b0, 1'b1, tag);
        end else begin
            pushExp(mq, msout, 1'b1, 1'b0, tag);
            for (int i = 1; i <= int'(cnt); i++) begin
                modelStep(m, s);
                pushExp(mq, msout, i < int'(cnt), i == int'(cnt), tag);
            end
        end
    endtask

    task automatic checkOutput(input bit waitEdge, output logic expBusy);
        exp_t e;
        if (waitEdge) begin
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        expBusy = e.busy;
        total++;
        assert (q === e.q) else begin
            bad++;
            $error("[TB] FAIL %s q: got %h want %h", e.tag, q, e.q);
        end
        total++;
        assert (sout === e.sout) else begin
            bad++;
            $error("[TB] FAIL %s sout: got %b want %b", e.tag, sout, e.sout);
        end
        total++;
        assert (busy === e.busy) else begin
            bad++;
            $error("[TB] FAIL %s busy: got %b want %b", e.tag, busy, e.busy);
        end
        total++;
        assert (done === e.done) else begin
            bad++;
            $error("[TB] FAIL %s done: got %b want %b", e.tag, done, e.done);
        end
    endtask

    // Called just after a rising edge; returns just after the done edge so a
    // following call drives start inside the done cycle.
    task automatic applyStimulus(input logic [2:0] m, input logic [3:0] cnt,
                                 input logic [7:0] p, input logic s,
                                 input bit poke, input string tag);
        logic eb;
        mode  = m;
        count = cnt;
        pin   = p;
        sin   = s;
        start = 1'b1;
        pushCmd(m, cnt, p, s, tag);
        while (sb.size() > 0) begin
            checkOutput(1'b1, eb);
            if (poke && eb) begin
                start = 1'b1;
                mode  = 3'b011;
                pin   = 8'h00;
                count = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic idleStep(input string tag);
        logic eb;
        pushExp(mq, msout, 1'b0, 1'b0, tag);
        checkOutput(1'b1, eb);
    endtask

    initial begin
        logic eb;
        total = 0;
        bad   = 0;
        mq    = 8'h00;
        msout = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        mode  = 3'b000;
        count = '0;
        sin   = 1'b0;
        pin   = 8'h00;

        #12;
        pushExp(8'h00, 1'b0, 1'b0, 1'b0, "reset");
        checkOutput(1'b0, eb);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset landing in the middle of a rotate burst.
        mode  = 3'b100;
        count = 4'd5;
        pin   = 8'h00;
        start = 1'b1;
        pushCmd(3'b100, 4'd5, 8'h00, 1'b0, "rst_mid");
        checkOutput(1'b1, eb);
        start = 1'b0;
        checkOutput(1'b1, eb);
        checkOutput(1'b1, eb);
        rst = 1'b0;
        #1;
        sb.delete();
        mq    = 8'h00;
        msout = 1'b0;
        pushExp(8'h00, 1'b0, 1'b0, 1'b0, "rst_async");
        checkOutput(1'b0, eb);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, "load_a5");
        idleStep("load_idle");

        applyStimulus(3'b100, 4'd3, 8'h00, 1'b0, 1'b1, "rol3_poke");
        applyStimulus(3'b101, 4'd1, 8'h00, 1'b0, 1'b0, "ror1_b2b");
        idleStep("ror_idle");

        applyStimulus(3'b011, 4'd0, 8'h81, 1'b0, 1'b0, "load_81");
        applyStimulus(3'b110, 4'd2, 8'h00, 1'b0, 1'b0, "asr2");

        applyStimulus(3'b011, 4'd0, 8'h0F, 1'b0, 1'b0, "load_0f");
        applyStimulus(3'b001, 4'd4, 8'h00, 1'b1, 1'b0, "shl4_fill1");
        applyStimulus(3'b010, 4'd8, 8'h00, 1'b0, 1'b0, "shr8_fill0");

        applyStimulus(3'b011, 4'd0, 8'h3C, 1'b0, 1'b0, "load_3c");
        applyStimulus(3'b000, 4'd5, 8'hFF, 1'b1, 1'b0, "hold");
        applyStimulus(3'b111, 4'd3, 8'hFF, 1'b1, 1'b0, "reserved");
        applyStimulus(3'b001, 4'd0, 8'hFF, 1'b1, 1'b0, "shl_cnt0");

        applyStimulus(3'b011, 4'd0, 8'h96, 1'b0, 1'b0, "load_96");
        applyStimulus(3'b100, 4'd8, 8'h00, 1'b0, 1'b0, "rol8_wrap");
        applyStimulus(3'b101, 4'd9, 8'h00, 1'b0, 1'b0, "ror9_over");
        applyStimulus(3'b001, 4'd15, 8'h00, 1'b1, 1'b0, "shl15_over");
        idleStep("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
